// File: rtl/pc_call_stack.sv
// Hack program counter with a hardware return-address stack.
// CALL pushes out+1 and jumps, RET pops into out; overflow/underflow are sticky.
module pc_call_stack #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           in,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_CLR,
    CMD_RET,
    CMD_RET_UF,
    CMD_CALL,
    CMD_CALL_OF,
    CMD_LOAD,
    CMD_INC
  } cmd_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             of_q, of_d;
  logic             uf_q, uf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  cmd_e             cmd;
  logic             push_en;
  logic [WIDTH-1:0] pc_inc;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             full_w;
  logic             empty_w;

  assign full_w  = (sp_q == SP_FULL);
  assign empty_w = (sp_q == '0);
  assign pc_inc  = out_q + 1'b1;
  assign wr_idx  = AW'(sp_q);
  assign rd_idx  = AW'(sp_q - 1'b1);

  // Priority decode: exactly one command acts per cycle.
  always_comb begin
    cmd = CMD_HOLD;
    if (clr)       cmd = CMD_CLR;
    else if (ret)  cmd = empty_w ? CMD_RET_UF : CMD_RET;
    else if (call) cmd = full_w ? CMD_CALL_OF : CMD_CALL;
    else if (load) cmd = CMD_LOAD;
    else if (inc)  cmd = CMD_INC;
  end

  always_comb begin
    out_d   = out_q;
    sp_d    = sp_q;
    of_d    = of_q;
    uf_d    = uf_q;
    push_en = 1'b0;
    case (cmd)
      CMD_CLR: begin
        out_d = RESET_VAL;
        sp_d  = '0;
        of_d  = 1'b0;
        uf_d  = 1'b0;
      end
      CMD_RET: begin
        out_d = stack_q[rd_idx];
        sp_d  = sp_q - 1'b1;
      end
      CMD_RET_UF:  uf_d = 1'b1;
      CMD_CALL: begin
        push_en = 1'b1;
        out_d   = in;
        sp_d    = sp_q + 1'b1;
      end
      CMD_CALL_OF: of_d = 1'b1;
      CMD_LOAD:    out_d = in;
      CMD_INC:     out_d = pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= RESET_VAL;
      sp_q  <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      sp_q  <= sp_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
    end
  end

  // Stack storage is deliberately not reset; unoccupied entries are don't-care.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[wr_idx] <= pc_inc;
  end

  assign out       = out_q;
  assign sp        = sp_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = of_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed and randomized checks of pc_call_stack (WIDTH=16, DEPTH=8).
module tb_pc_call_stack;

  logic        clk = 1'b0;
  logic        rst, clr, load, inc, call, ret;
  logic [15:0] din;
  logic [15:0] dout;
  logic [3:0]  sp;
  logic        full, empty, overflow, underflow;

  int errors = 0;
  int checks = 0;

  pc_call_stack #(.WIDTH(16), .DEPTH(8), .RESET_VAL(16'h0000)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .inc(inc), .call(call),
    .ret(ret), .in(din), .out(dout), .sp(sp), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic c, input logic r, input logic ca,
                       input logic l, input logic i, input logic [15:0] d);
    clr = c; ret = r; call = ca; load = l; inc = i; din = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 16'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 1, 16'h0);
    tick(); tick();
    checks++;
    if (dout !== 16'h0002) begin
      errors++; $display("FAIL pre_reset_inc: out=%h expected 0002", dout);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dout, sp, empty, full, overflow, underflow} !== {16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: out=%h sp=%0d empty=%b full=%b of=%b uf=%b expected 0000 0 1 0 0 0",
               dout, sp, empty, full, overflow, underflow);
    end
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0);
    tick();
  endtask

  task automatic test_inc_load();
    logic [15:0] exp_v [7];
    exp_v[0] = 16'h0001; exp_v[1] = 16'h0002; exp_v[2] = 16'h0003;
    exp_v[3] = 16'h7FFF; exp_v[4] = 16'h8000; exp_v[5] = 16'hFFFF; exp_v[6] = 16'h0000;
    for (int k = 0; k < 7; k++) begin
      case (k)
        3:       drive(0, 0, 0, 1, 0, 16'h7FFF);
        5:       drive(0, 0, 0, 1, 0, 16'hFFFF);
        default: drive(0, 0, 0, 0, 1, 16'h0);
      endcase
      tick();
      checks++;
      if (dout !== exp_v[k] || sp !== 4'd0) begin
        errors++; $display("FAIL inc_load[%0d]: out=%h sp=%0d expected %h 0", k, dout, sp, exp_v[k]);
      end
    end
  endtask

  task automatic test_call_ret();
    drive(0, 0, 0, 1, 0, 16'h0010); tick();
    drive(0, 0, 1, 0, 0, 16'h0100); tick();
    checks++;
    if (dout !== 16'h0100 || sp !== 4'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL call: out=%h sp=%0d empty=%b expected 0100 1 0", dout, sp, empty);
    end
    drive(0, 1, 0, 0, 0, 16'h0); tick();
    checks++;
    if (dout !== 16'h0011 || sp !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL ret: out=%h sp=%0d empty=%b expected 0011 0 1", dout, sp, empty);
    end
  endtask

  task automatic test_depth();
    logic [15:0] pushed [8];
    logic [15:0] cur;
    drive(1, 0, 0, 0, 0, 16'h0); tick();
    cur = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      pushed[k] = cur + 16'h0001;
      cur = 16'h1000 + 16'(k * 16);
      drive(0, 0, 1, 0, 0, cur); tick();
    end
    checks++;
    if (full !== 1'b1 || sp !== 4'd8 || dout !== cur || overflow !== 1'b0) begin
      errors++; $display("FAIL fill: full=%b sp=%0d out=%h of=%b expected 1 8 %h 0", full, sp, dout, overflow, cur);
    end
    drive(0, 0, 1, 0, 0, 16'hABCD); tick();
    checks++;
    if (overflow !== 1'b1 || sp !== 4'd8 || dout !== cur) begin
      errors++; $display("FAIL overflow: of=%b sp=%0d out=%h expected 1 8 %h", overflow, sp, dout, cur);
    end
    for (int k = 7; k >= 0; k--) begin
      drive(0, 1, 0, 0, 0, 16'h0); tick();
      checks++;
      if (dout !== pushed[k] || sp !== 4'(k)) begin
        errors++; $display("FAIL lifo[%0d]: out=%h sp=%0d expected %h %0d", k, dout, sp, pushed[k], k);
      end
    end
    drive(0, 1, 0, 0, 0, 16'h0); tick();
    checks++;
    if (underflow !== 1'b1 || dout !== 16'h0001 || sp !== 4'd0 || overflow !== 1'b1) begin
      errors++; $display("FAIL underflow: uf=%b out=%h sp=%0d of=%b expected 1 0001 0 1", underflow, dout, sp, overflow);
    end
  endtask

  task automatic test_simultaneous();
    drive(1, 0, 0, 0, 0, 16'h0); tick();
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || dout !== 16'h0000 || sp !== 4'd0) begin
      errors++; $display("FAIL clr_flags: of=%b uf=%b out=%h sp=%0d expected 0 0 0000 0", overflow, underflow, dout, sp);
    end
    drive(0, 0, 1, 0, 0, 16'h0200); tick();
    drive(0, 1, 1, 0, 0, 16'h0555); tick();
    checks++;
    if (dout !== 16'h0001 || sp !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL call_ret: out=%h sp=%0d of=%b uf=%b expected 0001 0 0 0", dout, sp, overflow, underflow);
    end
    drive(0, 0, 0, 1, 1, 16'h1234); tick();
    checks++;
    if (dout !== 16'h1234) begin
      errors++; $display("FAIL load_inc: out=%h expected 1234", dout);
    end
    drive(0, 0, 1, 0, 0, 16'h0300); tick();
    drive(1, 0, 1, 0, 0, 16'h0400); tick();
    checks++;
    if (dout !== 16'h0000 || sp !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL clr_call: out=%h sp=%0d empty=%b expected 0000 0 1", dout, sp, empty);
    end
    drive(0, 1, 0, 0, 0, 16'h0); tick();
    checks++;
    if (underflow !== 1'b1 || dout !== 16'h0000) begin
      errors++; $display("FAIL ret_after_clr: uf=%b out=%h expected 1 0000", underflow, dout);
    end
    drive(0, 0, 0, 1, 0, 16'hFFFF); tick();
    drive(0, 0, 1, 0, 0, 16'h0400); tick();
    drive(0, 1, 0, 0, 0, 16'h0); tick();
    checks++;
    if (dout !== 16'h0000 || sp !== 4'd0) begin
      errors++; $display("FAIL call_wrap: out=%h sp=%0d expected 0000 0", dout, sp);
    end
  endtask

  task automatic test_random();
    logic [15:0] m_out, m_stack [8];
    logic [3:0]  m_sp;
    logic        m_of, m_uf;
    logic        c, r, ca, l, i;
    logic [15:0] d;
    drive(1, 0, 0, 0, 0, 16'h0); tick();
    m_out = 16'h0; m_sp = 4'd0; m_of = 1'b0; m_uf = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      c  = ($urandom_range(0, 63) == 0);
      r  = ($urandom_range(0, 3) == 0);
      ca = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 3) == 0);
      i  = ($urandom_range(0, 1) == 0);
      d  = 16'($urandom);
      if (n % 500 < 4) d = 16'hFFFF;
      drive(c, r, ca, l, i, d);
      if (c) begin
        m_out = 16'h0; m_sp = 4'd0; m_of = 1'b0; m_uf = 1'b0;
      end else if (r) begin
        if (m_sp == 0) m_uf = 1'b1;
        else begin m_sp = m_sp - 1; m_out = m_stack[m_sp[2:0]]; end
      end else if (ca) begin
        if (m_sp == 8) m_of = 1'b1;
        else begin m_stack[m_sp[2:0]] = m_out + 16'h1; m_sp = m_sp + 1; m_out = d; end
      end else if (l) m_out = d;
      else if (i) m_out = m_out + 16'h1;
      tick();
      checks++;
      if ({dout, sp, full, empty, overflow, underflow} !==
          {m_out, m_sp, (m_sp == 4'd8), (m_sp == 4'd0), m_of, m_uf}) begin
        errors++;
        $display("FAIL random[%0d]: out=%h sp=%0d f=%b e=%b of=%b uf=%b expected %h %0d %b %b %b %b",
                 n, dout, sp, full, empty, overflow, underflow,
                 m_out, m_sp, (m_sp == 4'd8), (m_sp == 4'd0), m_of, m_uf);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0);
    test_reset();
    test_inc_load();
    test_call_ret();
    test_depth();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
